// File: rtl/lockpick_host.sv
// lockpick_host: player-side driver for the lockpick game core. Streams two 32-byte keys out and captures the 32-byte result.
// Optional result-vs-status pattern check is built when LOCKPICK_HOST_MSG_CHECK_EN is defined.
module lockpick_host #(
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [255:0] req_key_a,
  input  logic [255:0] req_key_b,
  output logic         game_start,
  output logic         game_input_enable,
  output logic [7:0]   game_input_data,
  input  logic         game_output_valid,
  input  logic [7:0]   game_output_data,
  input  logic [1:0]   game_status,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [1:0]   resp_code,
  output logic         resp_timeout,
  output logic [255:0] resp_msg,
  output logic         resp_mismatch
);

  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
  // Firing two counts early makes DONE visible exactly RESP_TIMEOUT cycles after the last key byte.
  localparam logic [TW-1:0] TO_FIRE = TW'((RESP_TIMEOUT > 1) ? RESP_TIMEOUT - 2 : 0);
  localparam logic [3:0]    GAP     = 4'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, START, SEND_A, SEND_B, WAIT_RESP, CAPTURE, DONE} state_t;
  state_t state, state_nxt;

  logic [255:0]  key_a, key_b, cur_key, msg_q;
  logic          armed, to_q;
  logic [1:0]    code_q;
  logic [4:0]    bidx;
  logic [3:0]    gcnt;
  logic [TW-1:0] tcnt;
  logic          sending, in_gap, adv, last_b, accept;

  assign sending = (state == SEND_A) || (state == SEND_B);
  assign in_gap  = (gcnt != 4'd0);
  // Byte index moves on at the end of the gap (or straight away with no gap).
  assign adv     = (GAP == 4'd0) ? 1'b1 : (gcnt == 4'd1);
  assign last_b  = (state == SEND_B) && (bidx == 5'd31) && !in_gap;
  assign accept  = req_valid && req_ready;
  assign cur_key = (state == SEND_B) ? key_b : key_a;

  assign req_ready         = (state == IDLE) && !resp_valid;
  assign game_start        = (state == START);
  assign game_input_enable = sending && !in_gap;
  assign game_input_data   = sending ? cur_key[{bidx, 3'b000} +: 8] : 8'h00;
  assign resp_valid        = (state == DONE);
  assign resp_code         = code_q;
  assign resp_timeout      = to_q;
  assign resp_msg          = msg_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = armed ? SEND_A : START;
      START:     state_nxt = SEND_A;
      SEND_A:    if ((bidx == 5'd31) && adv) state_nxt = SEND_B;
      SEND_B:    if (last_b) state_nxt = WAIT_RESP;
      WAIT_RESP: if (game_output_valid)    state_nxt = CAPTURE;
                 else if (tcnt == TO_FIRE) state_nxt = DONE;
      CAPTURE:   if (game_output_valid && (bidx == 5'd31)) state_nxt = DONE;
      DONE:      if (resp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_a  <= '0;
      key_b  <= '0;
      armed  <= 1'b0;
      bidx   <= '0;
      gcnt   <= '0;
      tcnt   <= '0;
      code_q <= '0;
      to_q   <= 1'b0;
      msg_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          key_a  <= req_key_a;
          key_b  <= req_key_b;
          bidx   <= '0;
          gcnt   <= '0;
          code_q <= '0;
          to_q   <= 1'b0;
          msg_q  <= '0;
        end
        SEND_A, SEND_B: begin
          tcnt <= '0;
          if (in_gap)      gcnt <= gcnt - 4'd1;
          else if (!last_b) gcnt <= GAP;
          if (adv) bidx <= bidx + 5'd1;
        end
        WAIT_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (game_output_valid) begin
            code_q      <= game_status;
            msg_q[7:0]  <= game_output_data;
            bidx        <= 5'd1;
          end else if (tcnt == TO_FIRE) begin
            to_q  <= 1'b1;
            armed <= 1'b0;
          end
        end
        CAPTURE: if (game_output_valid) begin
          msg_q[{bidx, 3'b000} +: 8] <= game_output_data;
          bidx <= bidx + 5'd1;
          // After an error the game waits directly for a new key A, so skip the next start pulse.
          if (bidx == 5'd31) begin
            if (code_q == 2'b01) armed <= 1'b1;
            else if (code_q[1])  armed <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOCKPICK_HOST_MSG_CHECK_EN
  logic [255:0] pattern;
  always_comb begin
    pattern = '0;
    case (code_q)
      2'b10:   pattern = {16{16'hFACE}};
      2'b01:   pattern = {16{16'hBAD0}};
      2'b11:   pattern = {16{16'hDEAD}};
      default: pattern = '0;
    endcase
  end
  // An idle status with a full capture has no valid pattern, so it always flags.
  assign resp_mismatch = (state == DONE) && !to_q && ((code_q == 2'b00) || (msg_q != pattern));
`else
  assign resp_mismatch = 1'b0;
`endif

endmodule

// File: doc/lockpick_host.md
Name: lockpick_host

Overview:
- Player-side driver for the lockpick game core.
- Accepts a 256-bit key pair per request and issues the game's start pulse when the game is idle.
- Streams key A, then key B, byte-serially on the game's input interface.
- Captures the 32-byte result stream and game status, and returns a decoded response.
- Sits between a CPU/test-harness request port and the game's byte interface.

Parameters:
- GAP_CYCLES, 0: idle cycles with game_input_enable low inserted between consecutive key bytes (0..15).
- RESP_TIMEOUT, 64: cycles allowed from the last key byte sent to the first game_output_valid.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  host can accept a request.
- req_key_a  in  256  key A; byte i = bits [i*8+7:i*8].
- req_key_b  in  256  key B; same byte order.
- game_start  out  1  one-cycle start pulse to the game.
- game_input_enable  out  1  qualifies game_input_data.
- game_input_data  out  8  key byte.
- game_output_valid  in  1  game result byte valid.
- game_output_data  in  8  game result byte.
- game_status  in  2  00 idle, 01 error, 10 win, 11 locked out.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_code  out  2  captured game_status; 00 on timeout.
- resp_timeout  out  1  no result arrived within RESP_TIMEOUT.
- resp_msg  out  256  captured result; byte i = i-th valid byte received.
- resp_mismatch  out  1  message/status disagreement (optional feature).

Behaviour:
- Reset: all outputs 0. State = IDLE. armed = 0. Byte, gap and timeout counters = 0. A reset mid-operation abandons the transfer; the system resets the game concurrently.
- req_ready = 1 only in IDLE with resp_valid = 0.
- A request is accepted on req_valid && req_ready. Both keys are latched internally. Input changes after acceptance are ignored.
- armed flag: set when a response with resp_code 01 is produced, because the game then waits directly for a new key A. Cleared on resp_code 10, resp_code 11, timeout, or reset.
- IDLE -> START on accept when armed = 0. IDLE -> SEND_A on accept when armed = 1; no start pulse is issued.
- START: game_start = 1 for exactly one cycle, then -> SEND_A.
  - First byte is driven the cycle after game_start.
- SEND_A and SEND_B:
  - Drive byte k (k = 0..31, LSB byte first) with game_input_enable = 1 for one cycle.
  - Then GAP_CYCLES cycles with enable = 0 and data held.
  - After byte 31 of A -> SEND_B, with the same gap rule applied between A31 and B0.
  - After byte 31 of B -> WAIT_RESP. The timeout counter is cleared.
  - game_input_enable is never high outside SEND_A/SEND_B.
- WAIT_RESP:
  - Timeout counter increments each cycle.
  - On game_output_valid: latch game_status into resp_code, store byte 0, count = 1, -> CAPTURE.
  - If the counter reaches RESP_TIMEOUT first: resp_code = 00, resp_timeout = 1, armed = 0, -> DONE.
- CAPTURE:
  - Each cycle with game_output_valid stores the byte at index count, then count++.
  - After byte 31 -> DONE.
  - A valid drop mid-stream is tolerated; capture simply waits.
  - Valids beyond 32 bytes are ignored.
- DONE: resp_valid = 1; resp_* held stable until resp_valid && resp_ready, then -> IDLE.
  - A request presented in that same cycle is not accepted (req_ready is still 0).
- Counters: byte index 5 bits, wraps only by state transition. Gap counter 4 bits. Timeout counter sized to hold RESP_TIMEOUT.

Optional Feature:
- Macro: LOCKPICK_HOST_MSG_CHECK_EN.
- With the macro defined:
  - At DONE (non-timeout), compare resp_msg against the expected 256-bit pattern for resp_code. Expected patterns, byte 0 first:
    - 10 -> repeating CE FA CE FA.
    - 01 -> repeating D0 BA D0 BA.
    - 11 -> repeating AD DE AD DE.
  - resp_mismatch = 1 on any difference, or on code 00 with a full capture.
- Without the macro: resp_mismatch tied 0 and the comparator is absent.

Test Plan:
- Reset, then req with key_a = 0, key_b = 0 against a game model returning error: one game_start pulse, 64 enabled bytes, all 0x00. Result is resp_code = 01, resp_msg byte0 = D0, byte1 = BA, armed = 1.
- Second req right after an error response: no game_start. First enabled byte = key_a[7:0] = 0x11 one cycle after accept+1. Locked-out model gives resp_code = 11 and byte0 = AD, and armed clears.
- GAP_CYCLES = 2 with key_a bytes 0x00..0x1F: enable pattern 1,0,0 repeating; bytes arrive in order 00, 01, ... 1F; 64 enables total.
- Model never asserts output_valid with RESP_TIMEOUT = 64: exactly 64 cycles after the last byte, resp_valid = 1, resp_timeout = 1, resp_code = 00. Next req issues game_start.
- Hold resp_ready = 0 for 10 cycles: resp_* stable and req_ready = 0 throughout. Assert rst mid-SEND_B: next cycle all outputs 0 and state IDLE.
- With LOCKPICK_HOST_MSG_CHECK_EN, model sends status 10 with byte 5 corrupted to 0x00: resp_mismatch = 1. With an uncorrupted FACEFACE stream: resp_mismatch = 0.
